// File: rtl/ksa_wb_sequencer_if.sv
// ---------------------------------------------------------------------------
// ksa_wb_sequencer_if
// Wishbone classic slave bus bundle between the management SoC port and the
// Kogge-Stone adder sequencer. Signal names keep the SoC's _i/_o direction
// as seen from the slave.
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : strobe / cycle / write enable
//   wbs_sel_i [3:0]                : byte selects
//   wbs_adr_i [31:0]               : byte address
//   wbs_dat_i [31:0]               : write data
//   wbs_ack_o                      : single-cycle acknowledge
//   wbs_dat_o [31:0]               : read data (valid while ack is high)
// ---------------------------------------------------------------------------
interface ksa_wb_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ksa_wb_sequencer.sv
// ---------------------------------------------------------------------------
// ksa_wb_sequencer
// Wishbone slave front end for the 16-bit Kogge-Stone adder. Holds the two
// operands written by the SoC, drives them onto the adder, waits a
// programmable settle time, then captures {cout, sum} into RESULT. Optional
// accumulate (a <- sum on capture) and done interrupt.
//
// Ports:
//   wb_clk_i         : clock
//   wb_rst_n_i       : synchronous active-low reset
//   wbs              : Wishbone slave bundle (ksa_wb_sequencer_if.slave)
//   add_a_o, add_b_o : adder operands (straight from operand registers)
//   add_sum_i        : adder sum
//   add_cout_i       : adder carry out
//   irq_o            : done interrupt (registered)
//
// Register map (adr[3:2]):
//   0 CTRL     W: [0] start, [2] clr   RW: [1] acc, [3] irq_en
//   1 OPERANDS RW {b, a}, byte-masked by wbs_sel_i
//   2 RESULT   RO {15'b0, cout, sum}
//   3 STATUS   RO [0] busy [1] done [2] carry_sticky [3] busy_err [15:8] cap_cnt
//
// Optional feature macro: KSA_SEQ_IRQ_EN. When undefined irq_o is tied low
// and CTRL[3] is not stored (reads 0).
// ---------------------------------------------------------------------------
module ksa_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  ksa_wb_sequencer_if.slave      wbs,
  output logic [15:0]            add_a_o,
  output logic [15:0]            add_b_o,
  input  logic [15:0]            add_sum_i,
  input  logic                   add_cout_i,
  output logic                   irq_o
);

  // Counter reload: the capture edge is the one where cnt reaches 0, so
  // loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES busy cycles.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [16:0] result_q, result_d;
  logic        done_q, done_d;
  logic        carry_sticky_q, carry_sticky_d;
  logic        busy_err_q, busy_err_d;
  logic [7:0]  cap_cnt_q, cap_cnt_d;
  logic        acc_q, acc_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        irq_en_s;
`ifdef KSA_SEQ_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
`endif

  logic        req_s, wr_s, rd_s, busy_s;
  logic        ctrl_wr_s, ops_wr_s, start_s, clr_s;
  logic [1:0]  idx_s;
  logic        unused_adr_s;

  // A new request is only taken while ack is low, which forces a dead cycle
  // between consecutive acks.
  assign req_s     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
                     (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_s      = req_s & wbs.wbs_we_i;
  assign rd_s      = req_s & ~wbs.wbs_we_i;
  assign idx_s     = wbs.wbs_adr_i[3:2];
  assign busy_s    = (state_q == SETTLE);
  assign ctrl_wr_s = wr_s & (idx_s == 2'd0);
  assign ops_wr_s  = wr_s & (idx_s == 2'd1);
  assign start_s   = ctrl_wr_s & wbs.wbs_dat_i[0];
  assign clr_s     = ctrl_wr_s & wbs.wbs_dat_i[2];
  assign unused_adr_s = ^wbs.wbs_adr_i[1:0];

`ifdef KSA_SEQ_IRQ_EN
  assign irq_en_s = irq_en_q;
`else
  assign irq_en_s = 1'b0;
`endif

  // Next-state computation for the bus slave, register file and settle FSM.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    done_d         = done_q;
    carry_sticky_d = carry_sticky_q;
    busy_err_d     = busy_err_q;
    cap_cnt_d      = cap_cnt_q;
    acc_d          = acc_q;
    ack_d          = req_s;
    dat_d          = 32'd0;
`ifdef KSA_SEQ_IRQ_EN
    irq_en_d       = irq_en_q;
    irq_d          = done_q & irq_en_q;
`endif

    // Read data is sampled before this edge's updates, so a read that
    // coincides with a capture returns the old RESULT.
    if (rd_s) begin
      case (idx_s)
        2'd0:    dat_d = {28'd0, irq_en_s, 1'b0, acc_q, 1'b0};
        2'd1:    dat_d = {b_q, a_q};
        2'd2:    dat_d = {15'd0, result_q};
        2'd3:    dat_d = {16'd0, cap_cnt_q, 4'd0, busy_err_q, carry_sticky_q,
                          done_q, busy_s};
        default: dat_d = 32'd0;
      endcase
    end else begin
      dat_d = 32'd0;
    end

    if (ctrl_wr_s) begin
      acc_d = wbs.wbs_dat_i[1];
`ifdef KSA_SEQ_IRQ_EN
      irq_en_d = wbs.wbs_dat_i[3];
`endif
    end else begin
      acc_d = acc_q;
    end

    // clr is applied before start/capture so a combined clr+start leaves a
    // fresh count that the following capture increments.
    if (clr_s) begin
      carry_sticky_d = 1'b0;
      busy_err_d     = 1'b0;
      cap_cnt_d      = 8'd0;
    end else begin
      carry_sticky_d = carry_sticky_q;
    end

    if (rd_s && (idx_s == 2'd2)) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    case (state_q)
      IDLE: begin
        if (ops_wr_s) begin
          if (wbs.wbs_sel_i[0]) a_d[7:0]  = wbs.wbs_dat_i[7:0];   else a_d[7:0]  = a_q[7:0];
          if (wbs.wbs_sel_i[1]) a_d[15:8] = wbs.wbs_dat_i[15:8];  else a_d[15:8] = a_q[15:8];
          if (wbs.wbs_sel_i[2]) b_d[7:0]  = wbs.wbs_dat_i[23:16]; else b_d[7:0]  = b_q[7:0];
          if (wbs.wbs_sel_i[3]) b_d[15:8] = wbs.wbs_dat_i[31:24]; else b_d[15:8] = b_q[15:8];
        end else begin
          b_d = b_q;
        end
        if (start_s) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
          done_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (start_s || ops_wr_s) begin
          busy_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Capture edge; a capture wins over a same-cycle RESULT read
          // clearing done.
          result_d       = {add_cout_i, add_sum_i};
          done_d         = 1'b1;
          carry_sticky_d = carry_sticky_d | add_cout_i;
          cap_cnt_d      = cap_cnt_d + 8'd1;
          if (acc_q) a_d = add_sum_i; else a_d = a_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      a_q            <= 16'd0;
      b_q            <= 16'd0;
      result_q       <= 17'd0;
      done_q         <= 1'b0;
      carry_sticky_q <= 1'b0;
      busy_err_q     <= 1'b0;
      cap_cnt_q      <= 8'd0;
      acc_q          <= 1'b0;
      ack_q          <= 1'b0;
      dat_q          <= 32'd0;
`ifdef KSA_SEQ_IRQ_EN
      irq_en_q       <= 1'b0;
      irq_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      result_q       <= result_d;
      done_q         <= done_d;
      carry_sticky_q <= carry_sticky_d;
      busy_err_q     <= busy_err_d;
      cap_cnt_q      <= cap_cnt_d;
      acc_q          <= acc_d;
      ack_q          <= ack_d;
      dat_q          <= dat_d;
`ifdef KSA_SEQ_IRQ_EN
      irq_en_q       <= irq_en_d;
      irq_q          <= irq_d;
`endif
    end
  end

  assign add_a_o       = a_q;
  assign add_b_o       = b_q;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
`ifdef KSA_SEQ_IRQ_EN
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule
